// File: rtl/chdr_pad_payload.sv
// chdr_pad_payload: pads CHDR packets that end before the line count in their
// header with zero-filled lines. Packets longer than their header length pass
// through unchanged and are counted.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HEADER | next accepted input beat is a CHDR header line
// ST_BODY   | inside a packet, lines_left lines still expected
// ST_PASS   | packet already exceeded its header length, pass to tlast
// ST_PAD    | emitting zero lines until pad_left reaches zero
module chdr_pad_payload #(
  parameter int CHDR_W = 64,
  parameter int USER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHDR_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [CHDR_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              ctrl_clear,
  output logic [15:0]       pad_pkt_count,
  output logic [15:0]       long_pkt_count
);

  localparam int unsigned BPL    = CHDR_W / 8;
  localparam int unsigned BPL_SH = $clog2(BPL);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_BODY   = 2'd1,
    ST_PASS   = 2'd2,
    ST_PAD    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lines_left_q, lines_left_d;
  logic [15:0]       pad_left_q, pad_left_d;
  logic [USER_W-1:0] tuser_q, tuser_d;
  logic [15:0]       pad_cnt_q, pad_cnt_d;
  logic [15:0]       long_cnt_q, long_cnt_d;

  logic [16:0]       len_round;
  logic [15:0]       lines_raw;
  logic [15:0]       hdr_lines_m1;
  logic [15:0]       body_left;
  logic              s_ready_int;
  logic              m_valid_int;
  logic              m_last_int;
  logic              s_beat;
  logic              pad_inc;
  logic              long_inc;

  // Header length to line count, rounding up; an empty packet still has its header line.
  always_comb begin
    len_round    = {1'b0, s_axis_tdata[47:32]} + 17'(BPL - 1);
    lines_raw    = 16'(len_round >> BPL_SH);
    hdr_lines_m1 = (lines_raw == 16'd0) ? 16'd0 : (lines_raw - 16'd1);
    body_left    = lines_left_q - 16'd1;
  end

  // Next-state, datapath muxing and handshake generation.
  always_comb begin
    state_d      = state_q;
    lines_left_d = lines_left_q;
    pad_left_d   = pad_left_q;
    tuser_d      = tuser_q;
    pad_inc      = 1'b0;
    long_inc     = 1'b0;
    m_axis_tdata = s_axis_tdata;
    m_axis_tuser = s_axis_tuser;
    m_last_int   = s_axis_tlast;
    m_valid_int  = s_axis_tvalid;
    s_ready_int  = m_axis_tready;

    if (state_q == ST_PAD) begin
      s_ready_int  = 1'b0;
      m_valid_int  = 1'b1;
      m_axis_tdata = '0;
      m_axis_tuser = tuser_q;
      m_last_int   = (pad_left_q == 16'd1);
    end

    s_beat = s_axis_tvalid && s_ready_int;
    if (s_beat) begin
      tuser_d = s_axis_tuser;
    end

    case (state_q)
      ST_HEADER: begin
        // tlast is dropped whenever the presented beat would start padding,
        // independent of the handshake, so it stays stable under backpressure.
        if (s_axis_tlast && (hdr_lines_m1 != 16'd0)) begin
          m_last_int = 1'b0;
        end
        if (s_beat) begin
          lines_left_d = hdr_lines_m1;
          if (s_axis_tlast && (hdr_lines_m1 != 16'd0)) begin
            state_d    = ST_PAD;
            pad_left_d = hdr_lines_m1;
            pad_inc    = 1'b1;
          end else if (s_axis_tlast) begin
            state_d = ST_HEADER;
          end else if (hdr_lines_m1 == 16'd0) begin
            state_d  = ST_PASS;
            long_inc = 1'b1;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (s_axis_tlast && (body_left != 16'd0)) begin
          m_last_int = 1'b0;
        end
        if (s_beat) begin
          lines_left_d = body_left;
          if (s_axis_tlast && (body_left != 16'd0)) begin
            state_d    = ST_PAD;
            pad_left_d = body_left;
            pad_inc    = 1'b1;
          end else if (s_axis_tlast) begin
            state_d = ST_HEADER;
          end else if (body_left == 16'd0) begin
            state_d  = ST_PASS;
            long_inc = 1'b1;
          end
        end
      end
      ST_PASS: begin
        if (s_beat && s_axis_tlast) begin
          state_d = ST_HEADER;
        end
      end
      ST_PAD: begin
        if (m_axis_tready) begin
          pad_left_d = pad_left_q - 16'd1;
          if (pad_left_q == 16'd1) begin
            state_d = ST_HEADER;
          end
        end
      end
      default: begin
        state_d = ST_HEADER;
      end
    endcase
  end

  // Handshakes and tlast are held idle for as long as reset is asserted.
  always_comb begin
    s_axis_tready = rst_n && s_ready_int;
    m_axis_tvalid = rst_n && m_valid_int;
    m_axis_tlast  = rst_n && m_last_int;
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_comb begin
    pad_cnt_d  = pad_cnt_q;
    long_cnt_d = long_cnt_q;
    if (ctrl_clear) begin
      pad_cnt_d  = '0;
      long_cnt_d = '0;
    end else begin
      if (pad_inc && (pad_cnt_q != 16'hFFFF)) begin
        pad_cnt_d = pad_cnt_q + 16'd1;
      end
      if (long_inc && (long_cnt_q != 16'hFFFF)) begin
        long_cnt_d = long_cnt_q + 16'd1;
      end
    end
  end

  // State, line tracking and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HEADER;
      lines_left_q <= '0;
      pad_left_q   <= '0;
      tuser_q      <= '0;
      pad_cnt_q    <= '0;
      long_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lines_left_q <= lines_left_d;
      pad_left_q   <= pad_left_d;
      tuser_q      <= tuser_d;
      pad_cnt_q    <= pad_cnt_d;
      long_cnt_q   <= long_cnt_d;
    end
  end

  assign pad_pkt_count  = pad_cnt_q;
  assign long_pkt_count = long_cnt_q;

endmodule

// File: tb/tb_chdr_pad_payload.sv
// Bench for chdr_pad_payload: directed packets with hand-chosen output line
// counts feed a scoreboard queue; a monitor compares every output beat.
module tb_chdr_pad_payload;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [15:0] s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [15:0] m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        ctrl_clear;
  logic [15:0] pad_cnt;
  logic [15:0] long_cnt;

  chdr_pad_payload #(.CHDR_W(64), .USER_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tuser   (s_tuser),
    .s_axis_tlast   (s_tlast),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .ctrl_clear     (ctrl_clear),
    .pad_pkt_count  (pad_cnt),
    .long_pkt_count (long_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [15:0] u;
    logic        l;
    logic        pad;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic bp_rand = 1'b0;

  logic        stall_prev = 1'b0;
  logic [63:0] hold_d;
  logic [15:0] hold_u;
  logic        hold_l;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Random output backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_rand) m_tready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", 64'(m_tvalid), 64'd1);
        chk("stall_tdata", m_tdata, hold_d);
        chk("stall_tuser", 64'(m_tuser), 64'(hold_u));
        chk("stall_tlast", 64'(m_tlast), 64'(hold_l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h with empty queue at %0t", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", m_tdata, e.d);
          chk("tuser", 64'(m_tuser), 64'(e.u));
          chk("tlast", 64'(m_tlast), 64'(e.l));
          if (e.pad) chk("pad_s_tready", 64'(s_tready), 64'd0);
        end
      end
      stall_prev = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_u = m_tuser;
      hold_l = m_tlast;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [15:0] u, input logic l);
    int  t;
    bit  done;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    t = 0;
    done = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      if (s_tready) done = 1;
      else t++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no s_tready expected handshake at %0t", $time);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // n_out is the hand-computed number of output lines for this packet.
  task automatic send_pkt(input logic [15:0] len, input int n_in, input int n_out,
                          input logic [15:0] ub);
    logic [63:0] d;
    exp_t e;
    for (int i = 0; i < n_in; i++) begin
      e.d   = (i == 0) ? {16'h0000, len, 16'hC0DE, ub} : {16'hB0D1, 16'(i), 16'h0000, ub};
      e.u   = ub + 16'(i);
      e.l   = (i == n_in - 1) && (n_out <= n_in);
      e.pad = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = n_in; i < n_out; i++) begin
      e.d   = 64'd0;
      e.u   = ub + 16'(n_in - 1);
      e.l   = (i == n_out - 1);
      e.pad = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n_in; i++) begin
      d = (i == 0) ? {16'h0000, len, 16'hC0DE, ub} : {16'hB0D1, 16'(i), 16'h0000, ub};
      send_beat(d, ub + 16'(i), i == n_in - 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    m_tready   = 1'b1;
    ctrl_clear = 1'b0;
    s_tvalid   = 1'b1;
    s_tlast    = 1'b1;
    s_tdata    = 64'h0123_4567_89AB_CDEF;
    s_tuser    = 16'h5A5A;
    #12;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata_mirror", m_tdata, 64'h0123_4567_89AB_CDEF);
    chk("rst_tuser_mirror", 64'(m_tuser), 64'h5A5A);
    chk("rst_pad_cnt", 64'(pad_cnt), 64'd0);
    chk("rst_long_cnt", 64'(long_cnt), 64'd0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Short packet: len=40 -> 5 lines, 3 sent.
    send_pkt(16'd40, 3, 5, 16'h0100);
    drain();
    chk("short_pad_cnt", 64'(pad_cnt), 64'd1);

    // Header-only short with rounding: len=20 -> 3 lines.
    send_pkt(16'd20, 1, 3, 16'h0200);
    drain();
    chk("hdr_only_pad_cnt", 64'(pad_cnt), 64'd2);

    // Exact, single-line and zero-length packets pass unchanged.
    send_pkt(16'd32, 4, 4, 16'h0300);
    send_pkt(16'd8, 1, 1, 16'h0400);
    send_pkt(16'd0, 1, 1, 16'h0500);
    drain();
    chk("exact_pad_cnt", 64'(pad_cnt), 64'd2);
    chk("exact_long_cnt", 64'(long_cnt), 64'd0);

    // Overlong: len=16 (2 lines) sent as 4, then a clean len=24 packet.
    send_pkt(16'd16, 4, 4, 16'h0600);
    send_pkt(16'd24, 3, 3, 16'h0700);
    drain();
    chk("long_long_cnt", 64'(long_cnt), 64'd1);
    chk("long_pad_cnt", 64'(pad_cnt), 64'd2);

    // Short packet under random backpressure.
    bp_rand = 1'b1;
    send_pkt(16'd40, 3, 5, 16'h0800);
    drain();
    bp_rand = 1'b0;
    @(negedge clk);
    m_tready = 1'b1;
    chk("bp_pad_cnt", 64'(pad_cnt), 64'd3);
    chk("bp_long_cnt", 64'(long_cnt), 64'd1);

    // Saturation: preload the pad counter, then pad one more packet.
    @(negedge clk);
    force dut.pad_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pad_cnt_q;
    chk("sat_preload", 64'(pad_cnt), 64'hFFFF);
    send_pkt(16'd16, 1, 2, 16'h0900);
    drain();
    chk("sat_hold", 64'(pad_cnt), 64'hFFFF);

    // Clear zeroes both counters.
    @(negedge clk);
    ctrl_clear = 1'b1;
    @(posedge clk);
    #1;
    ctrl_clear = 1'b0;
    chk("clear_pad_cnt", 64'(pad_cnt), 64'd0);
    chk("clear_long_cnt", 64'(long_cnt), 64'd1 - 64'd1);

    // Reset in the middle of padding.
    send_pkt(16'd40, 1, 5, 16'h0A00);
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midpad_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midpad_s_tready", 64'(s_tready), 64'd0);
    chk("midpad_m_tlast", 64'(m_tlast), 64'd0);
    exp_q.delete();
    m_tready = 1'b1;
    #1;
    chk("midpad_s_tready_rdy", 64'(s_tready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_pad_cnt", 64'(pad_cnt), 64'd0);
    @(posedge clk);
    #1;
    send_pkt(16'd24, 3, 3, 16'h0B00);
    drain();
    chk("post_rst_pad_cnt2", 64'(pad_cnt), 64'd0);
    chk("post_rst_long_cnt", 64'(long_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
